// File: rtl/clock_cfg_regs.sv
// clock_cfg_regs: register-side control upstream of the crypto clock mux.
// Holds the CLKSEL shadow register, synchronises and debounces the J16/K16
// DIP inputs, and sequences every configuration change through a settle
// window before presenting it to the mux. STATUS reports the decoded state.
// Optional build macro: CLKCFG_LOCK_EN (CLKSEL write with wdata[7]=1 locks
// further CLKSEL writes until reset).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | outputs match shadow/debounced values, nothing pending
// ST_HOLD  | change pending, counting down the settle window
// ST_APPLY | settle window done, capture values for the output stage
`timescale 1ns/1ps
module clock_cfg_regs #(
  parameter logic [7:0]  pADDR_CLKSEL = 8'h00,
  parameter logic [7:0]  pADDR_STATUS = 8'h01,
  parameter int unsigned pDEBOUNCE    = 16,
  parameter int unsigned pSETTLE      = 8
) (
  input  logic       usb_clk,
  input  logic       usb_rst_n,
  input  logic [7:0] I_reg_addr,
  input  logic       I_reg_wr,
  input  logic       I_reg_rd,
  input  logic [7:0] I_reg_wdata,
  output logic [7:0] O_reg_rdata,
  input  logic       I_j16_raw,
  input  logic       I_k16_raw,
  output logic [4:0] O_clock_reg,
  output logic       O_j16_sel,
  output logic       O_k16_sel,
  output logic       O_busy
);

  localparam int DBW = $clog2(pDEBOUNCE + 1);
  localparam int STW = $clog2(pSETTLE + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(pDEBOUNCE - 1);
  localparam logic [STW-1:0] ST_LAST = STW'(pSETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_APPLY} state_t;

  state_t           state_q, state_d;
  logic [STW-1:0]   cnt_q, cnt_d;
  logic [4:0]       shadow_q;
  logic             lock_q;
  logic [1:0]       dip_sync1_q, dip_sync2_q, dip_deb_q;
  logic [DBW-1:0]   dip_cnt_q [2];
  logic [6:0]       cfg_now, cfg_prev_q, stage_q;
  logic             apply_q;
  logic             pending;
  logic             wr_clksel;
  logic             src_is_ext, output_ext;
  logic             unused_wdata;

  // Bits 6:5 never carry meaning; bit 7 only matters in the lock build.
  assign unused_wdata = ^I_reg_wdata[7:5];

`ifdef CLKCFG_LOCK_EN
  assign wr_clksel = I_reg_wr && (I_reg_addr == pADDR_CLKSEL) && !lock_q;

  // Lock is sticky until reset once a CLKSEL write carries bit 7.
  always_ff @(posedge usb_clk) begin
    if (!usb_rst_n)
      lock_q <= 1'b0;
    else if (wr_clksel && I_reg_wdata[7])
      lock_q <= 1'b1;
  end
`else
  assign wr_clksel = I_reg_wr && (I_reg_addr == pADDR_CLKSEL);
  assign lock_q    = 1'b0;
`endif

  // CLKSEL shadow register, written from the bus.
  always_ff @(posedge usb_clk) begin
    if (!usb_rst_n)
      shadow_q <= '0;
    else if (wr_clksel)
      shadow_q <= I_reg_wdata[4:0];
  end

  // Two-flop synchronisers and per-input debounce (bit 0 = J16, bit 1 = K16).
  always_ff @(posedge usb_clk) begin
    if (!usb_rst_n) begin
      dip_sync1_q <= '0;
      dip_sync2_q <= '0;
      dip_deb_q   <= '0;
      for (int i = 0; i < 2; i++) dip_cnt_q[i] <= '0;
    end else begin
      dip_sync1_q <= {I_k16_raw, I_j16_raw};
      dip_sync2_q <= dip_sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (dip_sync2_q[i] != dip_deb_q[i]) begin
          if (dip_cnt_q[i] == DB_LAST) begin
            dip_deb_q[i] <= ~dip_deb_q[i];
            dip_cnt_q[i] <= '0;
          end else begin
            dip_cnt_q[i] <= dip_cnt_q[i] + DBW'(1);
          end
        end else begin
          dip_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign cfg_now = {shadow_q, dip_deb_q[1], dip_deb_q[0]};
  assign pending = cfg_now != {O_clock_reg, O_k16_sel, O_j16_sel};

  // Next-state logic; apply_q blocks re-entry while the output stage is
  // still loading, since pending compares against the old outputs then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pending && !apply_q) begin
          state_d = ST_HOLD;
          cnt_d   = ST_LAST;
        end
      end
      ST_HOLD: begin
        if (cfg_now != cfg_prev_q)
          cnt_d = ST_LAST;
        else if (cnt_q == '0)
          state_d = ST_APPLY;
        else
          cnt_d = cnt_q - STW'(1);
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; outputs load one edge after APPLY so that they
  // change on the same edge that busy falls.
  always_ff @(posedge usb_clk) begin
    if (!usb_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cfg_prev_q  <= '0;
      stage_q     <= '0;
      apply_q     <= 1'b0;
      O_busy      <= 1'b0;
      O_clock_reg <= '0;
      O_j16_sel   <= 1'b0;
      O_k16_sel   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_prev_q <= cfg_now;
      O_busy     <= (state_q != ST_IDLE);
      apply_q    <= (state_q == ST_APPLY);
      if (state_q == ST_APPLY)
        stage_q <= cfg_now;
      if (apply_q)
        {O_clock_reg, O_k16_sel, O_j16_sel} <= stage_q;
    end
  end

  // Source/output decode from the applied values.
  always_comb begin
    if (O_clock_reg[2:0] == 3'b001)
      src_is_ext = 1'b0;
    else if (O_clock_reg[2:0] == 3'b101)
      src_is_ext = 1'b1;
    else
      src_is_ext = !O_clock_reg[0] && O_j16_sel;

    if (O_clock_reg[0] && (O_clock_reg[4:3] == 2'b00))
      output_ext = 1'b0;
    else if (O_clock_reg[0] && (O_clock_reg[4:3] == 2'b01))
      output_ext = 1'b1;
    else
      output_ext = !O_clock_reg[0] && O_k16_sel;
  end

  // Registered read port; a same-cycle CLKSEL write is seen on the next read.
  always_ff @(posedge usb_clk) begin
    if (!usb_rst_n)
      O_reg_rdata <= '0;
    else if (I_reg_rd) begin
      if (I_reg_addr == pADDR_CLKSEL)
        O_reg_rdata <= {3'b000, shadow_q};
      else if (I_reg_addr == pADDR_STATUS)
        O_reg_rdata <= {2'b00, lock_q, O_busy, output_ext, src_is_ext,
                        O_k16_sel, O_j16_sel};
      else
        O_reg_rdata <= 8'h00;
    end
  end

endmodule

// File: tb/tb_clock_cfg_regs.sv
// Self-checking bench for clock_cfg_regs: directed timing cases plus a
// randomized sequence against a behavioural model of the register contents.
`timescale 1ns/1ps
module tb_clock_cfg_regs;

  localparam int         DEB    = 16;
  localparam int         SET    = 8;
  localparam logic [7:0] A_CLK  = 8'h00;
  localparam logic [7:0] A_ST   = 8'h01;

  logic       usb_clk, usb_rst_n;
  logic [7:0] I_reg_addr, I_reg_wdata, O_reg_rdata;
  logic       I_reg_wr, I_reg_rd, I_j16_raw, I_k16_raw;
  logic [4:0] O_clock_reg;
  logic       O_j16_sel, O_k16_sel, O_busy;

  clock_cfg_regs #(
    .pADDR_CLKSEL(A_CLK), .pADDR_STATUS(A_ST), .pDEBOUNCE(DEB), .pSETTLE(SET)
  ) dut (
    .usb_clk(usb_clk), .usb_rst_n(usb_rst_n),
    .I_reg_addr(I_reg_addr), .I_reg_wr(I_reg_wr), .I_reg_rd(I_reg_rd),
    .I_reg_wdata(I_reg_wdata), .O_reg_rdata(O_reg_rdata),
    .I_j16_raw(I_j16_raw), .I_k16_raw(I_k16_raw),
    .O_clock_reg(O_clock_reg), .O_j16_sel(O_j16_sel), .O_k16_sel(O_k16_sel),
    .O_busy(O_busy)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [4:0] m_shadow, m_clk;
  logic       m_j16, m_k16, m_lock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status(input logic [4:0] c, input logic j,
                                            input logic k, input logic lk, input logic bsy);
    logic src, oext;
    if (c[2:0] == 3'b001)      src = 1'b0;
    else if (c[2:0] == 3'b101) src = 1'b1;
    else                       src = (c[0] == 1'b0) && j;
    if (c[0] && c[4:3] == 2'b00)      oext = 1'b0;
    else if (c[0] && c[4:3] == 2'b01) oext = 1'b1;
    else                              oext = (c[0] == 1'b0) && k;
    return {2'b00, lk, bsy, oext, src, k, j};
  endfunction

  task automatic tick;
    @(posedge usb_clk);
    #1;
  endtask

  task automatic model_reset;
    m_shadow = '0; m_clk = '0; m_j16 = 1'b0; m_k16 = 1'b0; m_lock = 1'b0;
  endtask

  task automatic do_reset;
    usb_rst_n = 1'b0;
    tick; tick;
    usb_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    I_reg_addr = a; I_reg_wdata = d; I_reg_wr = 1'b1;
    tick;
    I_reg_wr = 1'b0;
    if (a == A_CLK) begin
`ifdef CLKCFG_LOCK_EN
      if (!m_lock) begin
        m_shadow = d[4:0];
        if (d[7]) m_lock = 1'b1;
      end
`else
      m_shadow = d[4:0];
`endif
    end
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    I_reg_addr = a; I_reg_rd = 1'b1;
    tick;
    I_reg_rd = 1'b0;
    d = O_reg_rdata;
  endtask

  task automatic wait_settle;
    int guard;
    repeat (3) tick;
    guard = 0;
    while (O_busy && guard < 80) begin
      tick;
      guard++;
    end
    if (O_busy) check("settle_timeout", 32'(O_busy), 0);
    m_clk = m_shadow;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] rd;
    check({tag, "_clk"},  O_clock_reg, m_clk);
    check({tag, "_j16"},  O_j16_sel,   m_j16);
    check({tag, "_k16"},  O_k16_sel,   m_k16);
    check({tag, "_busy"}, O_busy,      0);
    bus_read(A_ST, rd);
    check({tag, "_status"}, rd, exp_status(m_clk, m_j16, m_k16, m_lock, 1'b0));
    bus_read(A_CLK, rd);
    check({tag, "_clksel"}, rd, {3'b000, m_shadow});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int bad, e;
    usb_rst_n = 1'b1; I_reg_addr = '0; I_reg_wdata = '0;
    I_reg_wr = 1'b0; I_reg_rd = 1'b0; I_j16_raw = 1'b0; I_k16_raw = 1'b0;
    model_reset();
    do_reset();

    // Reset state.
    check("rst_clk",   O_clock_reg, 0);
    check("rst_j16",   O_j16_sel,   0);
    check("rst_k16",   O_k16_sel,   0);
    check("rst_busy",  O_busy,      0);
    check("rst_rdata", O_reg_rdata, 0);

    // Write 0x05: busy at edge 2, outputs and busy fall at edge SET+3.
    bus_write(A_CLK, 8'h05);
    tick;
    check("w5_busy_e1", O_busy, 0);
    tick;
    check("w5_busy_e2", O_busy, 1);
    repeat (SET) tick;
    check("w5_clk_e10",  O_clock_reg, 0);
    check("w5_busy_e10", O_busy, 1);
    tick;
    check("w5_clk_e11",  O_clock_reg, 5'b00101);
    check("w5_busy_e11", O_busy, 0);
    m_clk = m_shadow;
    bus_read(A_ST, rd);
    check("w5_status", rd, 8'h04);
    check("w5_status_model", rd, exp_status(m_clk, m_j16, m_k16, m_lock, 1'b0));

    // Second write four edges later restarts the settle window.
    do_reset();
    bus_write(A_CLK, 8'h01);
    repeat (3) tick;
    bus_write(A_CLK, 8'h09);
    bad = 0;
    for (int i = 5; i <= 14; i++) begin
      tick;
      if (O_clock_reg != 5'b00000 || !O_busy) bad++;
    end
    check("restart_no_intermediate", bad, 0);
    tick;
    check("restart_clk_e15",  O_clock_reg, 5'b01001);
    check("restart_busy_e15", O_busy, 0);
    m_clk = m_shadow;
    bus_read(A_ST, rd);
    check("restart_status", rd, 8'h08);

    // Reverted value still goes through APPLY with a full window.
    bus_write(A_CLK, 8'h03);
    tick;
    bus_write(A_CLK, 8'h09);
    bad = 0;
    for (int i = 3; i <= 12; i++) begin
      tick;
      if (O_clock_reg != 5'b01001 || !O_busy) bad++;
    end
    check("revert_hold", bad, 0);
    tick;
    check("revert_clk",  O_clock_reg, 5'b01001);
    check("revert_busy", O_busy, 0);

    // DIP glitch shorter than the debounce window is rejected.
    do_reset();
    I_j16_raw = 1'b1;
    repeat (10) tick;
    I_j16_raw = 1'b0;
    bad = 0;
    repeat (40) begin
      tick;
      if (O_busy || O_j16_sel) bad++;
    end
    check("dip_glitch", bad, 0);
    I_j16_raw = 1'b1;
    e = 0;
    while (!O_j16_sel && e < 80) begin
      tick;
      e++;
    end
    check("dip_latency_ok", 32'((e >= 2 + DEB + SET + 2) && (e <= 2 + DEB + SET + 3)), 1);
    m_j16 = 1'b1;
    wait_settle();
    bus_read(A_ST, rd);
    check("dip_status", rd, 8'h05);

    // Unmapped address: ignored on write, reads zero.
    bus_write(8'h7F, 8'hAA);
    bad = 0;
    repeat (12) begin
      tick;
      if (O_busy) bad++;
    end
    check("unmapped_busy", bad, 0);
    bus_read(8'h7F, rd);
    check("unmapped_rdata", rd, 8'h00);
    bus_read(A_CLK, rd);
    check("unmapped_clksel", rd, {3'b000, m_shadow});

    // Reset in the middle of HOLD discards the pending change.
    I_j16_raw = 1'b0;
    do_reset();
    bus_write(A_CLK, 8'h1F);
    repeat (4) tick;
    usb_rst_n = 1'b0;
    tick;
    check("hold_rst_clk",   O_clock_reg, 0);
    check("hold_rst_busy",  O_busy, 0);
    check("hold_rst_rdata", O_reg_rdata, 0);
    usb_rst_n = 1'b1;
    model_reset();
    repeat (15) tick;
    check("hold_rst_clk_after",  O_clock_reg, 0);
    check("hold_rst_busy_after", O_busy, 0);
    bus_read(A_CLK, rd);
    check("hold_rst_clksel", rd, 8'h00);

    // Simultaneous read and write returns the pre-write shadow.
    bus_write(A_CLK, 8'h0C);
    wait_settle();
    I_reg_addr = A_CLK; I_reg_wdata = 8'h13; I_reg_wr = 1'b1; I_reg_rd = 1'b1;
    tick;
    I_reg_wr = 1'b0; I_reg_rd = 1'b0;
    check("rdwr_old_shadow", O_reg_rdata, 8'h0C);
    m_shadow = 5'h13;
    wait_settle();
    check_all("rdwr");

    // Randomized writes, DIP changes and stray writes against the model.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        bus_write(A_CLK, 8'($urandom_range(0, 127)));
        wait_settle();
      end else if (op == 2) begin
        I_j16_raw = 1'($urandom_range(0, 1));
        I_k16_raw = 1'($urandom_range(0, 1));
        repeat (2 + DEB + 4) tick;
        m_j16 = I_j16_raw;
        m_k16 = I_k16_raw;
        wait_settle();
      end else begin
        bus_write(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)));
        wait_settle();
      end
      check_all($sformatf("rnd%0d", it));
    end

    // Lock behaviour (or its absence in the default build).
    I_j16_raw = 1'b0; I_k16_raw = 1'b0;
    do_reset();
    bus_write(A_CLK, 8'h81);
    wait_settle();
    bus_write(A_CLK, 8'h05);
    wait_settle();
`ifdef CLKCFG_LOCK_EN
    check("lock_clk", O_clock_reg, 5'b00001);
    bus_read(A_ST, rd);
    check("lock_status", rd, 8'h20);
`else
    check("nolock_clk", O_clock_reg, 5'b00101);
`endif
    check_all("lock");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
